// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, runs a request/valid handshake with a
// multi-cycle instruction memory, buffers one instruction for IF/ID.
module if_fetch_stage #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        branch_taken_i,
    input  logic [15:0] branch_target_i,
    output logic        imem_req_o,
    output logic [15:0] imem_addr_o,
    input  logic [15:0] imem_data_i,
    input  logic        imem_valid_i,
    output logic [15:0] inst_o,
    output logic [15:0] pc_o,
    output logic        fetch_valid_o,
    output logic        halted_o
);

    localparam logic [2:0] S_FETCH   = 3'd0;
    localparam logic [2:0] S_WAIT    = 3'd1;
    localparam logic [2:0] S_HOLD    = 3'd2;
    localparam logic [2:0] S_DISCARD = 3'd3;
    localparam logic [2:0] S_HALTED  = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] inst_q, inst_d;
    logic [15:0] target_pc;
    logic [15:0] pc_inc;

    assign target_pc = {branch_target_i[15:1], 1'b0};
    assign pc_inc    = pc_q + 16'd2;

    // A redirect wins over a stall in every state.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        case (state_q)
            S_FETCH: begin
                if (branch_taken_i) pc_d    = target_pc;
                else                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (branch_taken_i) begin
                    pc_d    = target_pc;
                    state_d = imem_valid_i ? S_FETCH : S_DISCARD;
                end else if (imem_valid_i) begin
                    inst_d  = imem_data_i;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (branch_taken_i) begin
                    pc_d    = target_pc;
                    state_d = S_FETCH;
                end else if (stall_i) begin
                    state_d = S_HOLD;
                end else if (inst_q[15:12] == HALT_OPCODE) begin
                    state_d = S_HALTED;
                end else begin
                    pc_d    = pc_inc;
                    state_d = S_FETCH;
                end
            end
            S_DISCARD: begin
                // Still owed a stale response; only its arrival frees the memory.
                if (branch_taken_i) pc_d    = target_pc;
                if (imem_valid_i)   state_d = S_FETCH;
            end
            S_HALTED: begin
                if (branch_taken_i) begin
                    pc_d    = target_pc;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            inst_q  <= 16'h0000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
        end
    end

    // Gated by rst so no request escapes while reset is held.
    assign imem_req_o    = ~rst & (state_q == S_FETCH) & ~branch_taken_i;
    assign imem_addr_o   = pc_q;
    assign fetch_valid_o = (state_q == S_HOLD) & ~branch_taken_i;
    assign halted_o      = (state_q == S_HALTED);
    assign inst_o        = inst_q;
    assign pc_o          = pc_inc;

endmodule
